// File: rtl/rssb_arb_pkg.sv
// Shared types and constants for the RSSB memory arbiter.
// Port 0 is the CPU core, port 1 the program loader / debug DMA.
package rssb_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rssb_arb_port_mux.sv
// Combinational 2:1 selector of the owning requester's access fields.
// sel_i = 0 picks port 0 (CPU), sel_i = 1 picks port 1 (loader).
module rssb_arb_port_mux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              sel_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o
);

  always_comb begin
    if (sel_i) begin
      req_o   = req1_i;
      we_o    = we1_i;
      addr_o  = addr1_i;
      wdata_o = wdata1_i;
    end else begin
      req_o   = req0_i;
      we_o    = we0_i;
      addr_o  = addr0_i;
      wdata_o = wdata0_i;
    end
  end

endmodule

// File: rtl/rssb_mem_arbiter.sv
// Two-port round-robin arbiter with bounded lock for the RSSB single-port memory.
// Handshake: reqX is a valid held until gntX; gntX is the ready; every cycle with reqX & gntX is one access.
module rssb_mem_arbiter
  import rssb_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOCK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int LCW = $clog2(MAX_LOCK) + 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);
  localparam logic [LCW-1:0] LOCK_ONE  = LCW'(1);

  arb_state_t        state_q, state_d, other_state;
  logic              rr_last_q, rr_last_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid0_q, rvalid1_q;

  logic              owner;
  logic              owned;
  logic              access;
  logic              sel_req, sel_we, sel_lock, oth_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign owned       = (state_q == OWN0) || (state_q == OWN1);
  assign owner       = (state_q == OWN1) ? PORT_LDR : PORT_CPU;
  assign other_state = (state_q == OWN1) ? OWN0 : OWN1;

  rssb_arb_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .sel_i    (owner),
    .req0_i   (req0),
    .we0_i    (we0),
    .addr0_i  (addr0),
    .wdata0_i (wdata0),
    .req1_i   (req1),
    .we1_i    (we1),
    .addr1_i  (addr1),
    .wdata1_i (wdata1),
    .req_o    (sel_req),
    .we_o     (sel_we),
    .addr_o   (sel_addr),
    .wdata_o  (sel_wdata)
  );

  assign sel_lock = owner ? lock1 : lock0;
  assign oth_req  = owner ? req0 : req1;
  assign access   = owned && sel_req;

  assign gnt0      = (state_q == OWN0);
  assign gnt1      = (state_q == OWN1);
  assign mem_we    = access && sel_we;
  assign mem_re    = access && !sel_we;
  // Outside an access the bus keeps presenting the last address/data.
  assign mem_addr  = access ? sel_addr : addr_q;
  assign mem_wdata = access ? sel_wdata : wdata_q;
  assign rdata     = rdata_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || rr_last_q)) state_d = OWN0;
        else if (req1)                    state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!sel_req) begin
          state_d = oth_req ? other_state : IDLE;
        end else if (sel_lock && (lock_cnt_q < LOCK_LAST)) begin
          lock_cnt_d = lock_cnt_q + LOCK_ONE;
        end else if (oth_req) begin
          state_d = other_state;
        end else if (lock_cnt_q != LOCK_LAST) begin
          lock_cnt_d = lock_cnt_q + LOCK_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Any new ownership restarts the lock window and records the winner.
    if ((state_d != state_q) && (state_d != IDLE)) begin
      rr_last_d  = (state_d == OWN1);
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      lock_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      lock_cnt_q <= lock_cnt_d;
      if (access) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (mem_re) rdata_q <= mem_rdata;
      rvalid0_q <= mem_re && (owner == PORT_CPU);
      rvalid1_q <= mem_re && (owner == PORT_LDR);
    end
  end

endmodule

// File: doc/rssb_mem_arbiter.md
Name: rssb_mem_arbiter

Overview:
- Two-requester arbiter for the single-port 8-bit memory system of the RSSB processor.
- Port 0 is the CPU core. Port 1 is the program loader / debug DMA.
- Owns the memory address, write-data and read/write strobes, and returns registered read data to the granted requester.
- Round-robin arbitration, a bounded lock for atomic read-then-write sequences, and a bubble-free ownership handover.

Parameters:
- ADDR_W, 8: memory address width.
- DATA_W, 8: memory data width.
- MAX_LOCK, 4: maximum consecutive granted cycles a locking owner may keep while the other port waits; must be ≥ 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req0, req1  input  1 each  access request from port 0 / port 1.
- lock0, lock1  input  1 each  requester asks to keep ownership after this access.
- we0, we1  input  1 each  1 = write, 0 = read.
- addr0, addr1  input  ADDR_W each  access address.
- wdata0, wdata1  input  DATA_W each  write data.
- gnt0, gnt1  output  1 each  port owns memory this cycle.
- rvalid0, rvalid1  output  1 each  one-cycle pulse: rdata holds this port's read result.
- rdata  output  DATA_W  captured read data.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_we, mem_re  output  1 each  memory strobes; read data is combinational within the cycle.
- mem_rdata  input  DATA_W  memory read data.

Behaviour:
- Reset:
  - Applies immediately: state IDLE, rr_last = 1 (port 0 favoured first), lock_cnt = 0.
  - All gnt, rvalid, mem_we and mem_re are 0; rdata, mem_addr and mem_wdata are 0.
  - Reset mid-access abandons the access; no write may occur while reset is high.
- State machine:
  - States: IDLE, OWN0, OWN1. gntX = (state == OWNX). Grant is registered from state; there is no combinational req→gnt path.
  - IDLE: only req0 → OWN0; only req1 → OWN1; both → the port ≠ rr_last; neither → stay.
  - Minimum latency is one cycle: req asserted in cycle n gives gnt in cycle n+1 from IDLE.
- Access in OWNX:
  - While reqX = 1, one access executes per cycle: mem_addr = addrX, mem_wdata = wdataX, mem_we = weX, mem_re = !weX.
  - While reqX = 0, no strobes are driven (mem_addr holds the last value).
  - A granted cycle with reqX = 0 is a release cycle.
- Read return:
  - mem_rdata is sampled into rdata at the end of a granted read cycle; rvalidX = 1 in the following cycle only.
  - rdata holds its value until the next captured read.
- Next-state from OWNX, where Y is the other port:
  - reqX = 0: go to OWNY if reqY, else IDLE.
  - reqX = 1, lockX = 1, lock_cnt < MAX_LOCK-1: stay; lock_cnt++.
  - reqX = 1 and either lock is not held or lock_cnt has reached MAX_LOCK-1: go to OWNY if reqY, else stay. If staying, lock_cnt++ saturating.
- Handover:
  - Every transition into OWNX sets rr_last = X and lock_cnt = 0.
  - OWNX→OWNY handover has no idle bubble.
  - A non-locking owner yields after every access when the other port is requesting, giving strict alternation.
- Lock bound:
  - Worst-case wait for a requesting port is MAX_LOCK cycles plus one arbitration cycle.
  - lock_cnt is a $clog2(MAX_LOCK)+1-bit counter.
- Requester rules:
  - Requesters hold req/addr/we/wdata stable until they see gnt.
  - Deasserting req before gnt withdraws the request; no access occurs.
- Width rules: addresses and data are passed unmodified, with no arithmetic.
- Invariants:
  - gnt0 & gnt1 is never 1.
  - mem_we & mem_re is never 1.
  - rvalid0 & rvalid1 is never 1.

Decomposition:
- Package rssb_arb_pkg:
  - arb_state_t enum {IDLE, OWN0, OWN1}.
  - Constants PORT_CPU = 0, PORT_LDR = 1.
  - Default widths ADDR_W / DATA_W.
- Sub-module rssb_arb_port_mux: a combinational 2:1 selector of {addr, wdata, we, req} by owner index. It keeps the FSM file free of datapath muxing.

Test Plan:
- Reset, then req0 = 1, we0 = 0, addr0 = 8'h10 with mem[10] = 8'h3C → gnt0 next cycle; mem_re = 1, mem_addr = 10; rvalid0 one cycle later with rdata = 3C; gnt1 stays 0.
- req0 and req1 both asserted from IDLE after reset, no lock → gnt order 0,1,0,1, one access per cycle, no idle cycle between grants.
- Port 1 write: lock1 = 1 held, req0 constant, MAX_LOCK = 4 → gnt1 exactly 4 consecutive cycles, then gnt0; 4 writes land in memory.
- Port 0 locked read 8'h20 followed by a write of 8'h55 to 8'h20 while req1 is pending → both accesses occur in back-to-back gnt0 cycles before gnt1; mem[20] = 55.
- Assert reset during an OWN1 write cycle → mem_we drops immediately, gnt1 = 0, state IDLE; post-reset simultaneous requests grant port 0 first.
- Random req/lock/we stimulus for 10k cycles → no dual grant, no dual strobe, every request granted within MAX_LOCK+1 cycles, and every read's rdata matches the memory model.
